// File: rtl/prog_fetch.sv
// Program fetch sequencer: 16-word instruction store, PC, FETCH/EXEC handshake
// with the core, and an EXEC watchdog that halts with a sticky error.
module prog_fetch #(
    parameter int WDOG_CYCLES = 32
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic        i_ld_en,
    input  logic [3:0]  i_ld_addr,
    input  logic [20:0] i_ld_word,
    input  logic [3:0]  i_p_c_out,
    output logic [20:0] o_pm_cont,
    output logic [3:0]  o_p_c,
    output logic        o_running,
    output logic        o_halted,
    output logic        o_err,
    output logic [7:0]  o_instr_count
);

    // state  | meaning
    // IDLE   | after reset; program may be loaded
    // FETCH  | one cycle, reads mem[p_c]; pm_cont held at NOP
    // EXEC   | instruction on pm_cont, waiting for p_c_out == p_c+1
    // HALT   | HALT opcode or watchdog fault; program may be reloaded
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;

    localparam int WDW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
    localparam logic [WDW-1:0] WDOG_LAST = WDW'(WDOG_CYCLES - 1);

    state_t          r_state;
    state_t          w_next;
    logic [20:0]     r_mem [16];
    logic [20:0]     r_pm_cont;
    logic [3:0]      r_p_c;
    logic            r_err;
    logic [7:0]      r_instr_count;
    logic [WDW-1:0]  r_wdog;

    logic [20:0]     w_fetch_word;
    logic [3:0]      w_pc_inc;
    logic            w_is_halt;
    logic            w_advance;
    logic            w_wdog_exp;
    logic            w_loadable;

    assign w_fetch_word = r_mem[r_p_c];
    assign w_pc_inc     = r_p_c + 4'd1;
    assign w_is_halt    = (w_fetch_word[3:0] == 4'b1111);
    assign w_advance    = (i_p_c_out == w_pc_inc);
    assign w_wdog_exp   = (r_wdog == WDOG_LAST);
    assign w_loadable   = (r_state == S_IDLE) || (r_state == S_HALT);

    always_ff @(posedge i_clock) begin
        if (i_reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_HALT: if (i_start) w_next = S_FETCH;
            S_FETCH:        w_next = w_is_halt ? S_HALT : S_EXEC;
            S_EXEC: begin
                if (w_advance)
                    w_next = S_FETCH;
                else if (w_wdog_exp)
                    w_next = S_HALT;
            end
            default:        w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_running = (r_state == S_FETCH) || (r_state == S_EXEC);
        o_halted  = (r_state == S_HALT);
    end

    // Program store has no reset so a reset keeps the loaded program.
    always_ff @(posedge i_clock) begin
        if (!i_reset && i_ld_en && w_loadable)
            r_mem[i_ld_addr] <= i_ld_word;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_p_c         <= 4'd0;
            r_pm_cont     <= 21'd0;
            r_err         <= 1'b0;
            r_instr_count <= 8'd0;
            r_wdog        <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_HALT: begin
                    if (i_start) begin
                        r_p_c         <= 4'd0;
                        r_instr_count <= 8'd0;
                        r_err         <= 1'b0;
                        r_pm_cont     <= 21'd0;
                    end
                end
                S_FETCH: begin
                    if (w_is_halt) begin
                        r_pm_cont <= 21'd0;
                    end else begin
                        r_pm_cont <= w_fetch_word;
                        r_wdog    <= '0;
                    end
                end
                S_EXEC: begin
                    if (w_advance) begin
                        r_p_c     <= i_p_c_out;
                        r_pm_cont <= 21'd0;
                        if (r_instr_count != 8'hFF)
                            r_instr_count <= r_instr_count + 8'd1;
                    end else if (w_wdog_exp) begin
                        r_err     <= 1'b1;
                        r_pm_cont <= 21'd0;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_pm_cont     = r_pm_cont;
    assign o_p_c         = r_p_c;
    assign o_err         = r_err;
    assign o_instr_count = r_instr_count;

endmodule

// File: tb/tb_prog_fetch.sv
// Bench for prog_fetch: a small core model drives p_c_out, and the expected
// instruction for each FETCH is queued and compared when it reaches pm_cont.
module tb_prog_fetch;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        ld_en = 1'b0;
    logic [3:0]  ld_addr = 4'd0;
    logic [20:0] ld_word = 21'd0;
    logic [3:0]  p_c_out = 4'd0;
    logic [20:0] pm_cont;
    logic [3:0]  p_c;
    logic        running;
    logic        halted;
    logic        err;
    logic [7:0]  instr_count;

    int n_vec = 0;
    int n_err = 0;
    logic [20:0] m_mem [16];
    logic [21:0] sb_q [$];

    always #5 clk = ~clk;

    prog_fetch #(.WDOG_CYCLES(32)) dut (
        .i_clock       (clk),
        .i_reset       (reset),
        .i_start       (start),
        .i_ld_en       (ld_en),
        .i_ld_addr     (ld_addr),
        .i_ld_word     (ld_word),
        .i_p_c_out     (p_c_out),
        .o_pm_cont     (pm_cont),
        .o_p_c         (p_c),
        .o_running     (running),
        .o_halted      (halted),
        .o_err         (err),
        .o_instr_count (instr_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic load_word(input logic [3:0] a, input logic [20:0] w);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_word = w;
        tick();
        ld_en   = 1'b0;
        m_mem[a] = w;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Called right after the start edge (DUT in FETCH at PC 0). The core
    // advances on the delay-th EXEC cycle; returns after n_max advances or a HALT.
    task automatic exec_program(input int delay, input int n_max, input bit poke);
        logic [3:0]  exp_pc = 4'd0;
        int          count = 0;
        logic [21:0] e;
        for (int it = 0; it <= n_max; it++) begin
            n_vec++;
            if (running !== 1'b1 || pm_cont !== 21'd0 || p_c !== exp_pc) begin
                n_err++;
                $display("FAIL fetch_state: running=%b pm_cont=%h p_c=%0d, required 1/0/%0d",
                         running, pm_cont, p_c, exp_pc);
            end
            sb_q.push_back({m_mem[exp_pc][3:0] == 4'hF, m_mem[exp_pc]});
            p_c_out = exp_pc;
            tick();
            e = sb_q.pop_front();
            if (e[21]) begin
                n_vec++;
                if (halted !== 1'b1 || running !== 1'b0 || pm_cont !== 21'd0 ||
                    p_c !== exp_pc || instr_count !== 8'(count)) begin
                    n_err++;
                    $display("FAIL halt_op: halted=%b running=%b pm_cont=%h p_c=%0d cnt=%0d, required 1/0/0/%0d/%0d",
                             halted, running, pm_cont, p_c, instr_count, exp_pc, count);
                end
                return;
            end
            n_vec++;
            if (pm_cont !== e[20:0] || running !== 1'b1 || halted !== 1'b0) begin
                n_err++;
                $display("FAIL exec_word pc%0d: pm_cont=%h running=%b, required %h/1",
                         exp_pc, pm_cont, running, e[20:0]);
            end
            for (int k = 1; k <= delay; k++) begin
                p_c_out = (k == delay) ? exp_pc + 4'd1 : exp_pc;
                if (poke && k == 1) begin
                    ld_en   = 1'b1;
                    ld_addr = 4'd5;
                    ld_word = 21'h0AAAA1;
                    start   = 1'b1;
                end
                tick();
                ld_en = 1'b0;
                start = 1'b0;
                if (k < delay) begin
                    n_vec++;
                    if (pm_cont !== e[20:0] || p_c !== exp_pc) begin
                        n_err++;
                        $display("FAIL exec_hold: pm_cont=%h p_c=%0d, required %h/%0d",
                                 pm_cont, p_c, e[20:0], exp_pc);
                    end
                end
            end
            exp_pc = exp_pc + 4'd1;
            count++;
            n_vec++;
            if (p_c !== exp_pc || instr_count !== 8'(count) || err !== 1'b0) begin
                n_err++;
                $display("FAIL advance: p_c=%0d cnt=%0d err=%b, required %0d/%0d/0",
                         p_c, instr_count, err, exp_pc, count);
            end
            if (count == n_max) return;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        start = 1'b0;
        n_vec++;
        if (running !== 1'b0 || halted !== 1'b0 || err !== 1'b0 || p_c !== 4'd0 ||
            pm_cont !== 21'd0 || instr_count !== 8'd0) begin
            n_err++;
            $display("FAIL reset_state: run=%b halt=%b err=%b p_c=%0d pm=%h cnt=%0d, required all 0",
                     running, halted, err, p_c, pm_cont, instr_count);
        end
    endtask

    task automatic test_single_halt();
        load_word(4'd0, 21'h00112);
        load_word(4'd1, 21'h0000F);
        do_start();
        exec_program(3, 16, 1'b0);
        n_vec++;
        if (halted !== 1'b1 || instr_count !== 8'd1 || p_c !== 4'd1) begin
            n_err++;
            $display("FAIL single_halt: halted=%b cnt=%0d p_c=%0d, required 1/1/1",
                     halted, instr_count, p_c);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 16; i++)
            load_word(4'(i), {8'(i + 1), 9'(i * 7), 4'(i % 15)});
        do_start();
        exec_program(2, 16, 1'b0);
        n_vec++;
        if (p_c !== 4'd0 || instr_count !== 8'd16 || err !== 1'b0 || running !== 1'b1) begin
            n_err++;
            $display("FAIL wrap: p_c=%0d cnt=%0d err=%b running=%b, required 0/16/0/1",
                     p_c, instr_count, err, running);
        end
    endtask

    task automatic test_reset_mid_exec();
        do_reset();
        do_start();
        exec_program(3, 3, 1'b0);
        p_c_out = 4'd3;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_vec++;
        if (running !== 1'b0 || halted !== 1'b0 || p_c !== 4'd0 || pm_cont !== 21'd0 ||
            instr_count !== 8'd0) begin
            n_err++;
            $display("FAIL reset_mid_exec: run=%b halt=%b p_c=%0d pm=%h cnt=%0d, required 0/0/0/0/0",
                     running, halted, p_c, pm_cont, instr_count);
        end
        do_start();
        exec_program(1, 1, 1'b0);
    endtask

    task automatic test_ld_ignored();
        do_reset();
        do_start();
        exec_program(2, 6, 1'b1);
    endtask

    task automatic test_ld_start_idle();
        do_reset();
        ld_en   = 1'b1;
        ld_addr = 4'd0;
        ld_word = 21'h155552;
        start   = 1'b1;
        tick();
        ld_en = 1'b0;
        start = 1'b0;
        m_mem[0] = 21'h155552;
        exec_program(1, 1, 1'b0);
    endtask

    task automatic test_watchdog(input logic [3:0] core_pc);
        int n = 0;
        do_start();
        tick();
        n_vec++;
        if (pm_cont !== m_mem[0] || running !== 1'b1) begin
            n_err++;
            $display("FAIL wdog_exec: pm_cont=%h running=%b, required %h/1", pm_cont, running, m_mem[0]);
        end
        p_c_out = core_pc;
        for (int i = 1; i <= 64; i++) begin
            tick();
            if (halted === 1'b1) begin
                n = i;
                break;
            end
        end
        n_vec++;
        if (n !== 32) begin
            n_err++;
            $display("FAIL wdog_cycles (p_c_out=%0d): halted after %0d EXEC cycles, required 32", core_pc, n);
        end
        n_vec++;
        if (err !== 1'b1 || halted !== 1'b1 || pm_cont !== 21'd0 || p_c !== 4'd0 ||
            instr_count !== 8'd0) begin
            n_err++;
            $display("FAIL wdog_fault: err=%b halted=%b pm=%h p_c=%0d cnt=%0d, required 1/1/0/0/0",
                     err, halted, pm_cont, p_c, instr_count);
        end
    endtask

    initial begin
        test_reset();
        test_single_halt();
        test_wrap();
        test_reset_mid_exec();
        test_ld_ignored();
        test_ld_start_idle();
        do_reset();
        load_word(4'd0, 21'h00013);
        test_watchdog(4'd0);
        test_watchdog(4'd2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/prog_fetch.md
PROG_FETCH -- requirements
Module: prog_fetch

Interface
REQ-001 Parameters SHALL be:
- WDOG_CYCLES, default 32: maximum EXEC cycles without PC advance before fault.
REQ-002 clock  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  pulse; begin execution at PC 0 (from IDLE or HALT).
REQ-005 ld_en  input  1  program-load write strobe.
REQ-006 ld_addr  input  4  program-memory write address.
REQ-007 ld_word  input  21  instruction word: data[20:13], op1[12:10], op2[9:7], op3[6:4], opcode[3:0].
REQ-008 p_c_out  input  4  next-PC value returned by the core.
REQ-009 pm_cont  output  21  registered instruction word presented to the core.
REQ-010 p_c  output  4  registered current program counter presented to the core.
REQ-011 running  output  1  high in FETCH or EXEC.
REQ-012 halted  output  1  high in HALT.
REQ-013 err  output  1  sticky watchdog fault flag.
REQ-014 instr_count  output  8  retired-instruction count.

Function
REQ-015 The block SHALL hold a 16 x 21 program memory; contents SHALL NOT be cleared by reset.
REQ-016 The FSM SHALL have states IDLE, FETCH, EXEC, HALT.
REQ-017 ld_en SHALL write ld_word to mem[ld_addr] only in IDLE or HALT; ld_en in FETCH/EXEC SHALL be ignored.
REQ-018 IDLE/HALT + start: p_c<=0, instr_count<=0, err<=0, pm_cont<=0, next state FETCH.
REQ-019 start in FETCH/EXEC SHALL be ignored.
REQ-020 If ld_en and start are both asserted in IDLE, the write SHALL complete and the FSM SHALL enter FETCH in the same edge.
REQ-021 FETCH lasts exactly one cycle.
- pm_cont is held at 0 (NOP opcode 0000) during FETCH.
- At the end of FETCH, if mem[p_c][3:0]==4'b1111 (HALT opcode): pm_cont<=0, next state HALT.
- Otherwise: pm_cont<=mem[p_c], watchdog counter<=0, next state EXEC.
REQ-022 In EXEC, pm_cont and p_c SHALL be held stable.
REQ-023 Each EXEC cycle, if p_c_out == (p_c+1) mod 16:
- p_c<=p_c_out;
- instr_count<=instr_count+1, saturating at 255;
- pm_cont<=0;
- next state FETCH.
REQ-024 Any other p_c_out value in EXEC SHALL be ignored (no jump support).
REQ-025 PC SHALL wrap 15 -> 0 without fault.
REQ-026 The watchdog counter SHALL increment every EXEC cycle without an advance.
- When it reaches WDOG_CYCLES-1 without an advance: err<=1, pm_cont<=0, next state HALT.
REQ-027 HALT SHALL hold p_c and instr_count and keep pm_cont=0 until start.
REQ-028 Fetch-to-execute latency SHALL be 1 cycle: an instruction is visible on pm_cont in the cycle after FETCH.
REQ-029 Per-instruction overhead SHALL be exactly 1 FETCH cycle beyond the core's execution cycles.

Reset
REQ-030 reset SHALL force, at the next edge and regardless of state or other inputs:
- state=IDLE;
- p_c=0, pm_cont=0;
- running=0, halted=0, err=0, instr_count=0;
- watchdog counter=0.
REQ-031 reset SHALL take priority over start and ld_en; a load write coincident with reset SHALL be dropped.
REQ-032 reset mid-EXEC SHALL abandon the current instruction; memory SHALL retain its contents.

Verification
REQ-033 Load mem[0]=0x00112 (load 0x00 to r?), mem[1]=0x0000F, start; core model returns p_c_out=1 after 3 cycles.
- Required: pm_cont=mem[0] one cycle after FETCH.
- Then FETCH at PC 1, HALT.
- halted=1, instr_count=1, p_c=1.
REQ-034 Load 16 non-HALT words, start; core model advances each instruction after 2 cycles.
- Required: p_c sequence 0..15, then 0.
- instr_count=16 after 16 advances; no err.
REQ-035 start with mem[0] opcode 0011; core model holds p_c_out=0.
- Required: after WDOG_CYCLES (32) EXEC cycles, err=1, halted=1, pm_cont=0, p_c=0.
REQ-036 Assert reset in the 2nd EXEC cycle of instruction 3.
- Required next cycle: IDLE, p_c=0, pm_cont=0, instr_count=0.
- After a new start, mem[0] is fetched unchanged.
REQ-037 Assert ld_en with ld_addr=5 during EXEC.
- Required: mem[5] unchanged, verified by a later fetch.
- Also: ld_en+start together in IDLE writes the word and enters FETCH.
REQ-038 Core model returns p_c_out=p_c+2 in EXEC.
- Required: ignored, no advance.
- Watchdog fault after 32 cycles.
